// File: rtl/plot_capture.sv
// rtl/plot_capture.sv - pixel-plot responder: frame store, registered readback, plot/oob counters, clear sweep
module plot_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic [2:0]  rd_colour,
    output logic        rd_valid,
    input  logic        clear_start,
    output logic        clear_done,
    output logic        busy,
    output logic [15:0] plot_count,
    output logic [7:0]  oob_count
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] W_L  = AW'(WIDTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t         r_state;
    logic           r_armed;
    logic [AW-1:0]  r_clr_addr;
    logic           r_busy;
    logic           r_done;
    logic [15:0]    r_plot_cnt;
    logic [7:0]     r_oob_cnt;
    logic [2:0]     r_rd_colour;
    logic           r_rd_valid;
    logic [2:0]     r_mem [DEPTH];

    logic           w_plot_inb;
    logic           w_rd_inb;
    logic [AW-1:0]  w_plot_addr;
    logic [AW-1:0]  w_rd_addr;
    logic           w_plot_acc;
    logic           w_plot_oob;
    logic           w_start;
    logic           w_mem_we;
    logic [AW-1:0]  w_mem_addr;
    logic [2:0]     w_mem_data;
    logic [2:0]     w_rd_data;

    assign w_plot_inb  = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
    assign w_rd_inb    = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign w_plot_addr = AW'(vga_y) * W_L + AW'(vga_x);
    assign w_rd_addr   = AW'(rd_y) * W_L + AW'(rd_x);

    assign w_plot_acc = vga_plot && w_plot_inb && (r_state != S_CLEAR);
    assign w_plot_oob = vga_plot && !w_plot_inb && (r_state != S_CLEAR);
    assign w_start    = (r_state == S_IDLE) && clear_start && r_armed;

    // The sweep owns the single write port while clearing; plots are dropped then.
    assign w_mem_we   = (r_state == S_CLEAR) || w_plot_acc;
    assign w_mem_addr = (r_state == S_CLEAR) ? r_clr_addr : w_plot_addr;
    assign w_mem_data = (r_state == S_CLEAR) ? 3'b000 : vga_colour;
    assign w_rd_data  = r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // r_armed blocks a held clear_start from re-triggering once the sweep has returned to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b1;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (!clear_start) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clear_start && r_armed) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                        r_armed    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_addr == LAST) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!clear_start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plot_cnt <= '0;
            r_oob_cnt  <= '0;
        end else if (w_start) begin
            r_plot_cnt <= '0;
            r_oob_cnt  <= '0;
        end else begin
            if (w_plot_acc && (r_plot_cnt != 16'hFFFF)) begin
                r_plot_cnt <= r_plot_cnt + 1'b1;
            end
            if (w_plot_oob && (r_oob_cnt != 8'hFF)) begin
                r_oob_cnt <= r_oob_cnt + 1'b1;
            end
        end
    end

    // Reads sample the store before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_rd_colour <= 3'b000;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_colour <= w_rd_inb ? w_rd_data : 3'b000;
            end
        end
    end

    assign rd_colour  = r_rd_colour;
    assign rd_valid   = r_rd_valid;
    assign clear_done = r_done;
    assign busy       = r_busy;
    assign plot_count = r_plot_cnt;
    assign oob_count  = r_oob_cnt;

endmodule
